// File: rtl/fifo_deq_serializer.sv
// fifo_deq_serializer: drains WIDTH*WORDS-bit elements from a first/deq queue and sends them as WIDTH-bit beats, low word first
module fifo_deq_serializer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4,
  parameter int BACK_TO_BACK = 1,
  parameter int CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [WIDTH*WORDS-1:0] in_first,
  input  logic                   in_first_rdy,
  input  logic                   in_deq_rdy,
  output logic                   in_deq_ena,
  output logic                   out_enq_ena,
  output logic [WIDTH-1:0]       out_enq_v,
  output logic                   out_enq_last,
  input  logic                   out_enq_rdy,
  output logic                   out_busy,
  output logic [CNT_W-1:0]       out_count
);
  localparam int BW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t                 state;
  logic [BW-1:0]          beat;
  logic [WIDTH*WORDS-1:0] hold;
  logic                   avail;
  logic                   last_beat;
  assign avail = in_first_rdy & in_deq_rdy;
  assign last_beat = (state == SEND) && (beat == BW'(WORDS - 1));
  assign out_busy = state == SEND;
  assign out_enq_ena = out_busy & out_enq_rdy;
  assign out_enq_last = last_beat;
  assign out_enq_v = out_busy ? hold[beat*WIDTH +: WIDTH] : '0;
  assign in_deq_ena = nRST & avail &
                      ((state == IDLE) | ((BACK_TO_BACK != 0) & out_enq_ena & last_beat));
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      beat      <= '0;
      hold      <= '0;
      out_count <= '0;
    end else begin
      if (in_deq_ena) begin
        hold  <= in_first;
        beat  <= '0;
        state <= SEND;
      end else if (out_enq_ena) begin
        if (last_beat) state <= IDLE;
        else beat <= beat + 1'b1;
      end
      if (out_enq_ena & last_beat) out_count <= out_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_deq_serializer.sv
// tb_fifo_deq_serializer: directed checks of fifo_deq_serializer with default, BACK_TO_BACK=0 and CNT_W=2 instances
module tb_fifo_deq_serializer;
  logic CLK = 0;
  logic nRST = 0;
  logic clr = 1;
  logic deq_rdy = 1;
  logic o_rdy = 1;
  logic [127:0] q [0:7];
  logic [3:0] n = 0;
  logic [3:0] h0, h1, h2;
  logic deq0, deq1, deq2, ena0, ena1, ena2, last0, last1, last2, busy0, busy1, busy2;
  logic [31:0] v0, v1, v2;
  logic [15:0] cnt0, cnt1;
  logic [1:0] cnt2;
  int total = 0;
  int bad = 0;
  logic [127:0] A = 128'h44444444_33333333_22222222_11111111;
  logic [127:0] B = 128'h88888888_77777777_66666666_55555555;
  logic [127:0] C = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    if (clr) begin
      h0 <= 0; h1 <= 0; h2 <= 0;
    end else begin
      if (deq0) h0 <= h0 + 1;
      if (deq1) h1 <= h1 + 1;
      if (deq2) h2 <= h2 + 1;
    end
  end
  fifo_deq_serializer u0 (
    .CLK(CLK), .nRST(nRST), .in_first(q[h0[2:0]]), .in_first_rdy(h0 < n), .in_deq_rdy(deq_rdy),
    .in_deq_ena(deq0), .out_enq_ena(ena0), .out_enq_v(v0), .out_enq_last(last0),
    .out_enq_rdy(o_rdy), .out_busy(busy0), .out_count(cnt0));
  fifo_deq_serializer #(.BACK_TO_BACK(0)) u1 (
    .CLK(CLK), .nRST(nRST), .in_first(q[h1[2:0]]), .in_first_rdy(h1 < n), .in_deq_rdy(deq_rdy),
    .in_deq_ena(deq1), .out_enq_ena(ena1), .out_enq_v(v1), .out_enq_last(last1),
    .out_enq_rdy(o_rdy), .out_busy(busy1), .out_count(cnt1));
  fifo_deq_serializer #(.CNT_W(2)) u2 (
    .CLK(CLK), .nRST(nRST), .in_first(q[h2[2:0]]), .in_first_rdy(h2 < n), .in_deq_rdy(deq_rdy),
    .in_deq_ena(deq2), .out_enq_ena(ena2), .out_enq_v(v2), .out_enq_last(last2),
    .out_enq_rdy(o_rdy), .out_busy(busy2), .out_count(cnt2));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] wd(input logic [127:0] x, input int i);
    return x[i*32 +: 32];
  endfunction
  task automatic do_reset();
    @(negedge CLK);
    nRST = 0; clr = 1; n = 0; deq_rdy = 1; o_rdy = 1;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("rst_deq", deq0, 0);
    check("rst_ena", ena0, 0);
    check("rst_v", v0, 0);
    check("rst_last", last0, 0);
    check("rst_busy", busy0, 0);
    check("rst_cnt", cnt0, 0);
    nRST = 1; clr = 0;
  endtask
  initial begin
    do_reset();
    q[0] = A; n = 1;
    #1 check("single_deq", deq0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); #1;
      check("single_ena", ena0, 1);
      check("single_v", v0, wd(A, i));
      check("single_last", last0, i == 3);
      check("single_deq_off", deq0, 0);
      check("single_busy", busy0, 1);
    end
    @(negedge CLK); #1;
    check("single_idle_busy", busy0, 0);
    check("single_idle_v", v0, 0);
    check("single_cnt", cnt0, 1);
    do_reset();
    q[0] = A; n = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      o_rdy = !(c == 2 || c == 3);
      #1;
      if (c <= 6) begin
        check("bp_ena", ena0, c != 2 && c != 3);
        check("bp_v", v0, c <= 1 ? wd(A, 0) : c <= 4 ? wd(A, 1) : wd(A, c - 3));
        check("bp_last", last0, c == 6);
      end else begin
        check("bp_busy", busy0, 0);
        check("bp_cnt", cnt0, 1);
      end
    end
    do_reset();
    q[0] = A; q[1] = B; n = 2;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK); #1;
      check("b2b_ena", ena0, c <= 8);
      check("b2b_v", v0, c <= 4 ? wd(A, c - 1) : c <= 8 ? wd(B, c - 5) : 32'h0);
      check("b2b_deq", deq0, c == 4);
      check("nb2b_ena", ena1, c <= 4 || (c >= 6 && c <= 9));
      check("nb2b_deq", deq1, c == 5);
      check("nb2b_v", v1, c <= 4 ? wd(A, c - 1) : (c >= 6 && c <= 9) ? wd(B, c - 6) : 32'h0);
      if (c == 9) check("b2b_cnt", cnt0, 2);
      if (c == 10) check("nb2b_cnt", cnt1, 2);
    end
    do_reset();
    q[0] = A; n = 1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge CLK); #1;
      check("mid_v", v0, wd(A, c - 1));
    end
    nRST = 0;
    @(negedge CLK); #1;
    check("mid_ena", ena0, 0);
    check("mid_v0", v0, 0);
    check("mid_last", last0, 0);
    check("mid_busy", busy0, 0);
    check("mid_deq", deq0, 0);
    check("mid_cnt", cnt0, 0);
    nRST = 1; q[1] = C; n = 2;
    #1 check("mid_new_deq", deq0, 1);
    @(negedge CLK); #1;
    check("mid_new_v", v0, wd(C, 0));
    check("mid_new_last", last0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) q[i] = {4{32'h01010101 * (i + 1)}};
    n = 5;
    for (int c = 1; c <= 21; c++) begin
      @(negedge CLK); #1;
      if (c <= 20) check("wrap_ena", ena2, 1);
      if (c % 4 == 1 && c > 1) check("wrap_cnt", cnt2, ((c - 1) / 4) % 4);
    end
    do_reset();
    deq_rdy = 0; q[0] = A; n = 1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check("blk_deq", deq0, 0);
      check("blk_ena", ena0, 0);
      check("blk_busy", busy0, 0);
      @(negedge CLK);
    end
    deq_rdy = 1;
    #1 check("blk_go_deq", deq0, 1);
    @(negedge CLK); #1;
    check("blk_go_v", v0, wd(A, 0));
    check("blk_go_busy", busy0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
